hex_display_driver: RTL

HEX_DISPLAY_DRIVER -- requirements
Module: hex_display_driver

---
 rtl/hex_display_driver_if.sv | 9 +
 rtl/hex_display_driver.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/hex_display_driver_if.sv
// Word handshake between the producer and the hex display driver.
interface hex_display_driver_if;
  logic [31:0] hexDisplay;
  logic        hex_valid;
  logic        hex_ready;

  modport master (output hexDisplay, output hex_valid, input hex_ready);
  modport slave  (input hexDisplay, input hex_valid, output hex_ready);
endinterface

// File: rtl/hex_display_driver.sv
// Eight-digit multiplexed hex display driver with a one-word pending buffer
// and frame-aligned word swap, so a digit never shows a half-updated frame.
module hex_display_driver #(
  parameter int unsigned SCAN_DIV = 50000
) (
  input  logic                       clk,
  input  logic                       reset_n,
  hex_display_driver_if.slave        hex,
  input  logic                       blank_lz,
  output logic [6:0]                 seg_n,
  output logic [7:0]                 dig_en_n,
  output logic                       frame_done
);

  typedef enum logic {OFF, SCAN} state_e;

  localparam logic [15:0] PC_LAST = 16'(SCAN_DIV - 1);

  state_e      state_q, state_d;
  logic [31:0] pend_q, pend_d;
  logic        pfull_q, pfull_d;
  logic [31:0] act_q, act_d;
  logic [15:0] pc_q, pc_d;
  logic [2:0]  dc_q, dc_d;
  logic [6:0]  seg_q, seg_d;
  logic [7:0]  dig_q, dig_d;
  logic        fd_q, fd_d;

  logic        accept, slot_end, wrap, blanked;
  logic [4:0]  nib_base;
  logic [3:0]  nib;

  function automatic logic [6:0] seg_decode(input logic [3:0] n);
    case (n)
      4'h0: return 7'h40;
      4'h1: return 7'h79;
      4'h2: return 7'h24;
      4'h3: return 7'h30;
      4'h4: return 7'h19;
      4'h5: return 7'h12;
      4'h6: return 7'h02;
      4'h7: return 7'h78;
      4'h8: return 7'h00;
      4'h9: return 7'h10;
      4'hA: return 7'h08;
      4'hB: return 7'h03;
      4'hC: return 7'h46;
      4'hD: return 7'h21;
      4'hE: return 7'h06;
      default: return 7'h0E;
    endcase
  endfunction

  assign hex.hex_ready = !pfull_q;
  assign accept        = hex.hex_valid && !pfull_q;
  assign slot_end      = (pc_q == PC_LAST);
  assign wrap          = (state_q == SCAN) && slot_end && (dc_q == 3'd7);
  assign nib_base      = {dc_q, 2'b00};
  assign nib           = act_q[nib_base +: 4];
  // Leading zero: everything from this nibble upward is zero (digit 0 always lit).
  assign blanked       = blank_lz && (dc_q != 3'd0) && ((act_q >> nib_base) == 32'd0);

  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    pfull_d = pfull_q;
    act_d   = act_q;
    pc_d    = pc_q;
    dc_d    = dc_q;
    seg_d   = 7'h7F;
    dig_d   = 8'hFF;
    fd_d    = 1'b0;

    unique case (state_q)
      OFF: begin
        pc_d = 16'd0;
        dc_d = 3'd0;
        if (pfull_q) begin
          act_d   = pend_q;
          pfull_d = 1'b0;
          state_d = SCAN;
        end
      end
      SCAN: begin
        // pc==0 keeps all digits dark for one cycle to suppress ghosting.
        if (pc_q != 16'd0 && !blanked) begin
          dig_d = ~(8'h01 << dc_q);
          seg_d = seg_decode(nib);
        end
        if (slot_end) begin
          pc_d = 16'd0;
          dc_d = dc_q + 3'd1;
        end else begin
          pc_d = pc_q + 16'd1;
        end
        if (wrap) begin
          fd_d = 1'b1;
          if (pfull_q) begin
            act_d   = pend_q;
            pfull_d = 1'b0;
          end
        end
      end
    endcase

    // Only possible with pfull_q==0, so it never collides with a transfer.
    if (accept) begin
      pend_d  = hex.hexDisplay;
      pfull_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= OFF;
      pend_q  <= 32'd0;
      pfull_q <= 1'b0;
      act_q   <= 32'd0;
      pc_q    <= 16'd0;
      dc_q    <= 3'd0;
      seg_q   <= 7'h7F;
      dig_q   <= 8'hFF;
      fd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      pfull_q <= pfull_d;
      act_q   <= act_d;
      pc_q    <= pc_d;
      dc_q    <= dc_d;
      seg_q   <= seg_d;
      dig_q   <= dig_d;
      fd_q    <= fd_d;
    end
  end

  assign seg_n      = seg_q;
  assign dig_en_n   = dig_q;
  assign frame_done = fd_q;

endmodule
